// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared types and constants for the matrix window timing controller
// Purpose: FSM state encoding, matrix generator latency, counter width helpers.
// Ports: none (package).
package matrix_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_FRAME = 2'b01,
      S_LINE  = 2'b10
   } state_e;

   // Register stages between an input pixel and the matching matrix_p11..p33 update.
   localparam int MATRIX_LAT = 2;

   function automatic int col_width(input int hdisp);
      return $clog2(hdisp + 1);
   endfunction

   function automatic int row_width(input int vdisp);
      return $clog2(vdisp + 1);
   endfunction

endpackage

// File: rtl/matrix_window_ctrl_if.sv
// rtl/matrix_window_ctrl_if.sv - video input and window output bundle
// Purpose: groups the vsync/href input and the window-valid/centre outputs.
// Ports: per_frame_vsync, per_frame_href (source -> ctrl); win_valid, win_row, win_col (ctrl -> sink).
// Modports: master = video source / window consumer, slave = matrix_window_ctrl.
interface matrix_window_ctrl_if #(
   parameter int CW = 10,
   parameter int RW = 9
) ();
   logic          per_frame_vsync;
   logic          per_frame_href;
   logic          win_valid;
   logic [RW-1:0] win_row;
   logic [CW-1:0] win_col;

   modport master (
      output per_frame_vsync, per_frame_href,
      input  win_valid, win_row, win_col
   );

   modport slave (
      input  per_frame_vsync, per_frame_href,
      output win_valid, win_row, win_col
   );
endinterface

// File: rtl/pipe_delay.sv
// rtl/pipe_delay.sv - fixed-depth register delay line
// Purpose: delays a bundle by DEPTH clocks so it lines up with the matrix generator output.
// Ports: clk, rst_n (async, active-low), d_i (WIDTH) in, q_o (WIDTH) out.
module pipe_delay
   import matrix_pkg::*;
#(
   parameter int WIDTH = 1,
   parameter int DEPTH = MATRIX_LAT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);
   logic [WIDTH-1:0] stage_q [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage_q <= '{default: '0};
      end else begin
         stage_q[0] <= d_i;
         for (int i = 1; i < DEPTH; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign q_o = stage_q[DEPTH-1];
endmodule

// File: rtl/matrix_window_ctrl.sv
// rtl/matrix_window_ctrl.sv - row/column timing controller for the 3x3 matrix window generator
// Purpose: counts rows/columns of accepted frames, flags full in-image windows with their centre
//          coordinates aligned to the matrix output, pulses frame/line events, flags malformed frames.
// Ports: clk, rst_n (async, active-low), ctrl_en, vid (slave: vsync/href in, win_valid/row/col out),
//        line_done, frame_start, frame_done, err_hlen, err_vlen, busy.
module matrix_window_ctrl
   import matrix_pkg::*;
#(
   parameter int IMG_HDISP = 640,
   parameter int IMG_VDISP = 480,
   parameter int CW        = col_width(IMG_HDISP),
   parameter int RW        = row_width(IMG_VDISP)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ctrl_en,
   matrix_window_ctrl_if.slave  vid,
   output logic                 line_done,
   output logic                 frame_start,
   output logic                 frame_done,
   output logic                 err_hlen,
   output logic                 err_vlen,
   output logic                 busy
);
   localparam logic [CW-1:0] HD = CW'(IMG_HDISP);
   localparam logic [RW-1:0] VD = RW'(IMG_VDISP);
   localparam int            PW = 1 + RW + CW + 1;

   state_e        state_q;
   logic          vsync_q, href_q, vs_armed_q;
   logic [RW-1:0] row_q;
   logic [CW-1:0] col_q;
   logic          line_done_q, frame_start_q, frame_done_q, err_hlen_q, err_vlen_q;

   logic          vsync, href, vsync_rise, vsync_fall, href_fall, line_close;
   logic [RW-1:0] row_inc, row_after;

   assign vsync = vid.per_frame_vsync;
   assign href  = vid.per_frame_href;

   // A rise only counts once vsync has been seen low since reset, so a reset in
   // the middle of a frame waits for the next genuine frame start.
   assign vsync_rise = vsync & ~vsync_q & vs_armed_q;
   assign vsync_fall = ~vsync & vsync_q;
   assign href_fall  = ~href & href_q;

   assign line_close = (state_q == S_LINE) && href_fall;
   assign row_inc    = (row_q == VD) ? row_q : row_q + RW'(1);
   // Frame length check sees the line that closes in the same cycle.
   assign row_after  = line_close ? row_inc : row_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         vsync_q       <= 1'b0;
         href_q        <= 1'b0;
         vs_armed_q    <= 1'b0;
         row_q         <= '0;
         col_q         <= '0;
         line_done_q   <= 1'b0;
         frame_start_q <= 1'b0;
         frame_done_q  <= 1'b0;
         err_hlen_q    <= 1'b0;
         err_vlen_q    <= 1'b0;
      end else begin
         vsync_q       <= vsync;
         href_q        <= href;
         if (!vsync) vs_armed_q <= 1'b1;
         line_done_q   <= 1'b0;
         frame_start_q <= 1'b0;
         frame_done_q  <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (vsync_rise && ctrl_en) begin
                  state_q       <= S_FRAME;
                  frame_start_q <= 1'b1;
                  err_hlen_q    <= 1'b0;
                  err_vlen_q    <= 1'b0;
                  row_q         <= '0;
                  col_q         <= '0;
               end
            end
            S_FRAME: begin
               if (href) begin
                  state_q <= S_LINE;
                  col_q   <= CW'(1);
               end
            end
            S_LINE: begin
               if (href) begin
                  if (col_q == HD) err_hlen_q <= 1'b1;
                  else             col_q      <= col_q + CW'(1);
               end else if (href_fall) begin
                  if (col_q != HD) err_hlen_q <= 1'b1;
                  line_done_q <= 1'b1;
                  row_q       <= row_inc;
                  col_q       <= '0;
                  state_q     <= S_FRAME;
               end
            end
            default: state_q <= S_IDLE;
         endcase

         if ((state_q != S_IDLE) && vsync_fall) begin
            frame_done_q <= 1'b1;
            if (row_after != VD) err_vlen_q <= 1'b1;
            state_q <= S_IDLE;
         end
      end
   end

   // Window decision for the pixel on the input this cycle (r = row_q, c = col_q).
   // Last row/column and overflow pixels are excluded so a centre is always in-image.
   logic          pix_valid, full;
   logic [PW-1:0] pipe_d, pipe_q;
   logic          d_full, d_href;
   logic [RW-1:0] d_row, win_row_q;
   logic [CW-1:0] d_col, win_col_q;

   assign pix_valid = href && (state_q != S_IDLE);
   assign full      = pix_valid && (row_q >= RW'(2)) && (row_q < VD)
                                && (col_q >= CW'(2)) && (col_q < HD);
   assign pipe_d    = {full, row_q - RW'(1), col_q - CW'(1), pix_valid};

   pipe_delay #(.WIDTH(PW), .DEPTH(MATRIX_LAT)) u_pipe (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (pipe_d),
      .q_o   (pipe_q)
   );

   assign {d_full, d_row, d_col, d_href} = pipe_q;

   // Coordinates only move on a valid window, so they hold through href gaps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_row_q <= '0;
         win_col_q <= '0;
      end else if (d_href && d_full) begin
         win_row_q <= d_row;
         win_col_q <= d_col;
      end
   end

   assign vid.win_valid = d_href && d_full;
   assign vid.win_row   = vid.win_valid ? d_row : win_row_q;
   assign vid.win_col   = vid.win_valid ? d_col : win_col_q;

   assign line_done   = line_done_q;
   assign frame_start = frame_start_q;
   assign frame_done  = frame_done_q;
   assign err_hlen    = err_hlen_q;
   assign err_vlen    = err_vlen_q;
   assign busy        = (state_q != S_IDLE);
endmodule

// File: tb/tb_matrix_window_ctrl.sv
// tb/tb_matrix_window_ctrl.sv - self-checking bench for matrix_window_ctrl
module tb_matrix_window_ctrl;
   localparam int HD = 8;
   localparam int VD = 6;
   localparam int CW = 4;
   localparam int RW = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic ctrl_en = 1'b0;
   logic line_done, frame_start, frame_done, err_hlen, err_vlen, busy;

   matrix_window_ctrl_if #(.CW(CW), .RW(RW)) vif ();

   matrix_window_ctrl #(.IMG_HDISP(HD), .IMG_VDISP(VD)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ctrl_en     (ctrl_en),
      .vid         (vif),
      .line_done   (line_done),
      .frame_start (frame_start),
      .frame_done  (frame_done),
      .err_hlen    (err_hlen),
      .err_vlen    (err_vlen),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          fs, ld, fd, eh, ev, bsy, wv;
      logic [RW-1:0] wr;
      logic [CW-1:0] wc;
   } obs_t;

   typedef struct {
      bit en; int n_lines; int short_idx; int short_len; bit joint;
      int e_fs; int e_ld; int e_fd; int e_win; bit e_errh; bit e_errv; bit e_busy; int e_joint;
   } frame_rec_t;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   // Reference model: frame/line bookkeeping from the event rules, window from pixel position.
   bit m_prev_v, m_prev_h, m_active, m_inline, m_errh, m_errv;
   int m_px, m_lines;
   bit pend_v; int pend_r, pend_c; int e_wr, e_wc;

   // Observed per-frame statistics.
   int cnt_fs, cnt_ld, cnt_fd, cnt_win, cnt_joint; bit busy_seen;
   bit fw_seen; int fw_row, fw_col, fw_cyc, pix_cyc;
   int line_len [16];

   function automatic void chk(input string name, input int got, input int exp);
      vectors++;
      if (got != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endfunction

   function automatic int outs();
      return int'({frame_start, line_done, frame_done, err_hlen, err_vlen, busy,
                   vif.win_valid, vif.win_row, vif.win_col});
   endfunction

   function automatic void m_reset();
      m_prev_v = 1'b1;   // no rise until vsync has been sampled low
      m_prev_h = 1'b0;
      m_active = 0; m_inline = 0; m_errh = 0; m_errv = 0;
      m_px = 0; m_lines = 0;
      pend_v = 0; pend_r = 0; pend_c = 0; e_wr = 0; e_wc = 0;
   endfunction

   function automatic void clear_counts();
      cnt_fs = 0; cnt_ld = 0; cnt_fd = 0; cnt_win = 0; cnt_joint = 0; busy_seen = 0;
      fw_seen = 0; fw_row = -1; fw_col = -1; fw_cyc = 0; pix_cyc = 0;
   endfunction

   task automatic step(input logic v, input logic h);
      bit rise, fall, hfall, e_fs, e_ld, e_fd, cur_v;
      int cur_r, cur_c;
      obs_t got, exp;
      rise  = v && !m_prev_v;
      fall  = !v && m_prev_v;
      hfall = !h && m_prev_h;
      e_fs = 0; e_ld = 0; e_fd = 0;
      cur_v = m_active && h && (m_lines >= 2) && (m_lines < VD) && (m_px >= 2) && (m_px < HD);
      cur_r = m_lines - 1;
      cur_c = m_px - 1;
      if (!m_active) begin
         if (rise && ctrl_en) begin
            m_active = 1; e_fs = 1; m_errh = 0; m_errv = 0;
            m_px = 0; m_lines = 0; m_inline = 0;
         end
      end else begin
         if (h) begin
            if (m_px == HD) m_errh = 1;
            else m_px++;
            m_inline = 1;
         end else if (hfall && m_inline) begin
            if (m_px != HD) m_errh = 1;
            e_ld = 1;
            if (m_lines < VD) m_lines++;
            m_px = 0; m_inline = 0;
         end
         if (fall) begin
            e_fd = 1;
            if (m_lines != VD) m_errv = 1;
            m_active = 0; m_inline = 0;
         end
      end
      m_prev_v = v; m_prev_h = h;

      vif.per_frame_vsync = v;
      vif.per_frame_href  = h;
      @(posedge clk);
      cyc++;
      #1;
      if (pend_v) begin e_wr = pend_r; e_wc = pend_c; end
      exp.fs = e_fs; exp.ld = e_ld; exp.fd = e_fd; exp.eh = m_errh; exp.ev = m_errv;
      exp.bsy = m_active; exp.wv = pend_v; exp.wr = RW'(e_wr); exp.wc = CW'(e_wc);
      got = {frame_start, line_done, frame_done, err_hlen, err_vlen, busy,
             vif.win_valid, vif.win_row, vif.win_col};
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL cycle %0d outputs fs/ld/fd/eh/ev/busy/wv: got %b row=%0d col=%0d expected %b row=%0d col=%0d",
                  cyc, got[RW+CW+6:RW+CW], got.wr, got.wc, exp[RW+CW+6:RW+CW], exp.wr, exp.wc);
      end
      pend_v = cur_v; pend_r = cur_r; pend_c = cur_c;

      cnt_fs += int'(got.fs); cnt_ld += int'(got.ld); cnt_fd += int'(got.fd);
      cnt_win += int'(got.wv); cnt_joint += int'(got.ld && got.fd);
      if (got.bsy) busy_seen = 1;
      if (got.wv && !fw_seen) begin
         fw_seen = 1; fw_row = int'(got.wr); fw_col = int'(got.wc); fw_cyc = cyc;
      end
   endtask

   task automatic run_frame(input bit en, input int n_lines, input bit joint,
                            input int gap_lo, input int gap_hi);
      clear_counts();
      ctrl_en = en;
      repeat (3) step(1, 0);
      for (int l = 0; l < n_lines; l++) begin
         for (int p = 0; p < line_len[l]; p++) begin
            if (l == 2 && p == 2) pix_cyc = cyc;
            step(1, 1);
         end
         if (l != n_lines - 1) begin
            int g;
            g = $urandom_range(gap_hi, gap_lo);
            repeat (g) step(1, 0);
         end
      end
      if (!joint) repeat (3) step(1, 0);
      repeat (5) step(0, 0);
   endtask

   task automatic check_frame(input frame_rec_t r, input string tag);
      chk({tag, "_frame_start"}, cnt_fs, r.e_fs);
      chk({tag, "_line_done"}, cnt_ld, r.e_ld);
      chk({tag, "_frame_done"}, cnt_fd, r.e_fd);
      chk({tag, "_win_valid"}, cnt_win, r.e_win);
      chk({tag, "_err_hlen"}, int'(err_hlen), int'(r.e_errh));
      chk({tag, "_err_vlen"}, int'(err_vlen), int'(r.e_errv));
      chk({tag, "_busy_seen"}, int'(busy_seen), int'(r.e_busy));
      chk({tag, "_joint_pulses"}, cnt_joint, r.e_joint);
      if (r.e_win > 0) begin
         chk({tag, "_first_win_row"}, fw_row, 1);
         chk({tag, "_first_win_col"}, fw_col, 1);
         chk({tag, "_first_win_latency"}, fw_cyc - pix_cyc, 2);
      end
   endtask

   function automatic void fill_lines(input int short_idx, input int short_len);
      for (int i = 0; i < 16; i++) line_len[i] = (i == short_idx) ? short_len : HD;
   endfunction

   frame_rec_t tbl [6];

   initial begin
      //         en lines sidx slen joint fs ld fd win  eh ev busy joint
      tbl[0] = '{1, 6, -1, 0, 0, 1, 6, 1, 24, 0, 0, 1, 0};  // nominal
      tbl[1] = '{1, 6,  3, 7, 0, 1, 6, 1, 23, 1, 0, 1, 0};  // short line 3
      tbl[2] = '{1, 5, -1, 0, 0, 1, 5, 1, 18, 0, 1, 1, 0};  // short frame
      tbl[3] = '{0, 6, -1, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0};  // disabled, errors stay sticky
      tbl[4] = '{1, 6, -1, 0, 0, 1, 6, 1, 24, 0, 0, 1, 0};  // nominal after disabled
      tbl[5] = '{1, 6, -1, 0, 1, 1, 6, 1, 24, 0, 0, 1, 1};  // href and vsync fall together

      m_reset();
      clear_counts();
      vif.per_frame_vsync = 1'b0;
      vif.per_frame_href  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", outs(), 0);
      rst_n = 1'b1;
      repeat (3) step(0, 0);

      for (int i = 0; i < 6; i++) begin
         fill_lines(tbl[i].short_idx, tbl[i].short_len);
         run_frame(tbl[i].en, tbl[i].n_lines, tbl[i].joint, 4, 4);
         check_frame(tbl[i], $sformatf("tbl%0d", i));
      end

      // Reset asserted for 2 cycles in the middle of line 3.
      fill_lines(-1, 0);
      clear_counts();
      ctrl_en = 1'b1;
      repeat (3) step(1, 0);
      for (int l = 0; l < 3; l++) begin
         repeat (HD) step(1, 1);
         repeat (4) step(1, 0);
      end
      repeat (4) step(1, 1);
      rst_n = 1'b0;
      m_reset();
      #1;
      chk("mid_reset_outputs", outs(), 0);
      repeat (2) @(posedge clk);
      cyc += 2;
      #1;
      chk("mid_reset_held_outputs", outs(), 0);
      rst_n = 1'b1;
      clear_counts();
      repeat (4) step(1, 1);
      repeat (4) step(1, 0);
      for (int l = 4; l < 6; l++) begin
         repeat (HD) step(1, 1);
         repeat (4) step(1, 0);
      end
      repeat (5) step(0, 0);
      chk("post_reset_frame_start", cnt_fs, 0);
      chk("post_reset_line_done", cnt_ld, 0);
      chk("post_reset_frame_done", cnt_fd, 0);
      chk("post_reset_win_valid", cnt_win, 0);
      chk("post_reset_busy_seen", int'(busy_seen), 0);
      run_frame(1, 6, 0, 4, 4);
      check_frame(tbl[0], "after_reset");

      // Randomized frames checked cycle by cycle against the model.
      for (int f = 0; f < 12; f++) begin
         int n;
         n = $urandom_range(7, 4);
         for (int l = 0; l < 16; l++)
            line_len[l] = ($urandom_range(3, 0) != 0) ? HD : $urandom_range(10, 6);
         run_frame($urandom_range(3, 0) != 0, n, $urandom_range(1, 0) == 1, 1, 5);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
